oam_dma_arbiter: RTL
====================

Name: oam_dma_arbiter

Overview:
- Owns FF46 (DMA) and runs the 160-byte OAM DMA transfer from a source page into OAM at FE00-FE9F.
- Arbitrates the shared memory paths (cart/iram/vram source reads) between CPU, DMA and video.
- Blocks CPU bus access outside FF00-FFFF while a transfer runs.
- Sits between the CPU decode and the video/OAM, iram, vram and cart ports in the top-level gb core.

Parameters:
- CYCLES_PER_BYTE, 4: clocks per transferred byte; must be at least 2.
- START_DELAY, 4: clocks between the FF46 write and the first byte slot.
- NUM_BYTES, 160: bytes per transfer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_sel  in  1  CPU address decodes to FF46.
- cpu_wr  in  1  CPU write strobe, active high.
- cpu_addr  in  16  current CPU address, used for blocking.
- cpu_di  in  8  CPU write data.
- cpu_do  out  8  FF46 readback.
- video_rd  in  1  video is fetching VRAM this cycle.
- dma_active  out  1  transfer in progress, including the start delay.
- cpu_blocked  out  1  CPU access must be ignored; reads return FF.
- src_rd  out  1  DMA owns the source memory path.
- src_addr  out  16  DMA source address.
- src_data  in  8  source read data, 1-clock synchronous latency.
- oam_wr  out  1  OAM write strobe.
- oam_addr  out  8  OAM byte index, 0-159.
- oam_data  out  8  OAM write data.
- dma_done  out  1  one-clock pulse when a transfer completes.

Behaviour:
Reset:
- Asynchronous, active-high. All outputs are 0 except cpu_do=8'h00.
- State returns to IDLE immediately, including mid-transfer.
- OAM keeps any bytes already written; there is no resume after reset.

Register:
- A write when cpu_sel && cpu_wr latches hi=cpu_di.
- cpu_do=hi.
- The effective page is ehi = (hi>=8'hE0) ? hi-8'h20 : hi.

States: IDLE, START, XFER.
- IDLE -> START on an FF46 write; the delay counter loads START_DELAY-1.
- START: dma_active=1; the counter decrements; -> XFER with idx=0, k=0 when the counter reaches 0.
- XFER byte slot, k = 0..CYCLES_PER_BYTE-1:
  - src_rd=1 and src_addr={ehi,idx} for the whole slot.
  - At k=CYCLES_PER_BYTE-1: oam_wr=1, oam_addr=idx, oam_data=src_data.
  - Then idx increments and k returns to 0.
- After the write with idx=NUM_BYTES-1: -> IDLE, dma_done=1 for one clock, dma_active=0 on that same clock.

Latency and stall:
- Unstalled, dma_active is high for START_DELAY + NUM_BYTES*CYCLES_PER_BYTE clocks, starting the clock after the write. Defaults give 644.
- VRAM conflict applies when ehi[7:5]==3'b100, video_rd=1 and k=0.
- During a conflict the slot does not advance: src_rd=0, k stays at 0, and the stall clocks extend dma_active.
- video_rd is ignored once k>0, because the slot already owns VRAM.

Restart:
- An FF46 write while in START or XFER updates hi and goes to START with a fresh delay and idx=0.
- No oam_wr is issued on the write clock; no dma_done is issued for the aborted run.

Blocking:
- cpu_blocked = dma_active && cpu_addr[15:8]!=8'hFF. This includes OAM FE00-FE9F.
- The FF46 write itself is never blocked.

Simultaneous events:
- An FF46 write on the final-byte clock: that final oam_wr still occurs, dma_done is suppressed, and the restart wins.
- oam_wr and src_rd are never asserted while in IDLE.

Width rules:
- idx is 8 bits and never exceeds NUM_BYTES-1.
- k is sized as clog2(CYCLES_PER_BYTE).

Test Plan:
1. Write FF46=8'hC1 with iram C100-C19F = index pattern -> dma_active rises next clock and stays high exactly 644 clocks; OAM[i]=i; a single dma_done pulse; first src_addr=16'hC100, last src_addr=16'hC19F.
2. Write FF46=8'hF1 -> src_addr starts at 16'hD100; cpu_do reads 8'hF1.
3. Source 8'h80, video_rd high for 10 clocks at the start of byte 5 -> byte 5 slot delayed 10 clocks; dma_active lasts 654 clocks; OAM contents correct.
4. During an active transfer, CPU reads C000, FE00 and FF80 -> cpu_blocked=1, 1, 0 respectively.
5. Rewrite FF46=8'hC2 after 50 bytes -> dma_active stays high, restart at idx 0 from 16'hC200, only one dma_done, 644 clocks after the second write.
6. Assert reset at byte 80 -> outputs 0 asynchronously, state IDLE, no dma_done; the next FF46 write runs a full 644-clock transfer.

Source files
------------

// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - FF46 OAM DMA engine with CPU blocking and VRAM-read arbitration
module oam_dma_arbiter #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4,
  parameter int NUM_BYTES       = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_sel,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic        video_rd,
  output logic        dma_active,
  output logic        cpu_blocked,
  output logic        src_rd,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        oam_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        dma_done
);

  localparam int KW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(NUM_BYTES - 1);
  localparam logic [DW-1:0] D_LOAD   = DW'(START_DELAY - 1);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t        state;
  logic [7:0]    hi;
  logic [7:0]    ehi;
  logic [7:0]    idx;
  logic [KW-1:0] k;
  logic [DW-1:0] dcnt;
  logic          reg_wr;
  logic          in_xfer;
  logic          stall;
  logic          slot_end;

  assign reg_wr   = cpu_sel && cpu_wr;
  // Echo-RAM pages E0-FF fold back onto C0-DF.
  assign ehi      = (hi >= 8'hE0) ? hi - 8'h20 : hi;
  assign in_xfer  = (state == XFER);
  // Video only wins the VRAM path at the very start of a slot.
  assign stall    = in_xfer && (k == '0) && (ehi[7:5] == 3'b100) && video_rd;
  assign slot_end = in_xfer && (k == K_LAST);

  assign cpu_do      = hi;
  assign dma_active  = (state != IDLE);
  assign cpu_blocked = dma_active && (cpu_addr < 16'hFF00);
  assign src_rd      = in_xfer && !stall;
  assign src_addr    = in_xfer ? {ehi, idx} : 16'h0000;
  // A restart aborts the pending byte, except the final byte which still lands.
  assign oam_wr      = slot_end && (!reg_wr || (idx == IDX_LAST));
  assign oam_addr    = oam_wr ? idx : 8'h00;
  assign oam_data    = oam_wr ? src_data : 8'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hi       <= 8'h00;
      idx      <= 8'h00;
      k        <= '0;
      dcnt     <= '0;
      dma_done <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      if (reg_wr) begin
        hi    <= cpu_di;
        state <= START;
        dcnt  <= D_LOAD;
        idx   <= 8'h00;
        k     <= '0;
      end else begin
        case (state)
          START: begin
            if (dcnt == '0) begin
              state <= XFER;
              idx   <= 8'h00;
              k     <= '0;
            end else begin
              dcnt <= dcnt - 1'b1;
            end
          end
          XFER: begin
            if (!stall) begin
              if (k == K_LAST) begin
                k <= '0;
                if (idx == IDX_LAST) begin
                  state    <= IDLE;
                  dma_done <= 1'b1;
                end else begin
                  idx <= idx + 8'd1;
                end
              end else begin
                k <= k + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
